power_domain_sequencer: RTL and testbench
=========================================

# power_domain_sequencer

Sequences one power-gated domain of the MCU through ordered power-down and power-up steps: clock gate, isolation, reset, then power switch, and the reverse for power-up. It waits for the switch-cell acknowledge and times out if the acknowledge never arrives. One instance sits between the software-visible power-control registers and each domain's switch, isolation, reset and clock-gate nets (CPU, peripheral, external domains). Its outputs directly replace constant tie-offs such as a hard-wired `switch_n = '1`.

## Interface
- `STEP_CYCLES`, default 2: dwell cycles held in each sequencing step, ≥1.
- `ACK_TIMEOUT`, default 64: maximum cycles spent waiting for the switch ack, ≥2.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `req_valid_i` input 1: power request valid.
- `req_on_i` input 1: requested target (1 = power on, 0 = power off); sampled with `req_valid_i`.
- `req_ready_o` output 1: request accepted when `req_valid_i & req_ready_o`.
- `switch_ack_ni` input 1: switch-cell ack, asynchronous to `clk_i`. Low = powered.
- `switch_no` output 1: 1 = switch closed (domain powered), 0 = open.
- `iso_no` output 1: 0 = domain outputs isolated.
- `rst_no` output 1: 0 = domain held in reset.
- `clkgate_en_no` output 1: 0 = domain clock gated.
- `on_o` output 1: domain is in the stable ON state.
- `busy_o` output 1: sequence in progress.
- `done_o` output 1: one-cycle pulse on reaching ON or OFF.
- `err_o` output 1: sticky ack-timeout flag.

## Operation
- States: `ON`, `D_CLK`, `D_ISO`, `D_RST`, `D_SW`, `D_ACK`, `OFF`, `U_SW`, `U_ACK`, `U_RST`, `U_ISO`, `U_CLK`.
- Power-down path: `ON` → `D_CLK` → `D_ISO` → `D_RST` → `D_SW` → `D_ACK` → `OFF`.
- Power-up path: `OFF` → `U_SW` → `U_ACK` → `U_RST` → `U_ISO` → `U_CLK` → `ON`.
- `D_CLK`, `D_ISO`, `D_RST`, `D_SW`:
  - On entry, drive the named output to its asserted value: clkgate_en 0, iso 0, rst 0, switch 0.
  - Dwell exactly `STEP_CYCLES` cycles, then advance.
  - Earlier outputs keep their asserted values.
- `U_SW`, `U_RST`, `U_ISO`, `U_CLK`:
  - On entry, release the named output: switch 1, rst 1, iso 1, clkgate_en 1.
  - Dwell exactly `STEP_CYCLES` cycles, except `U_CLK`, which advances to `ON` after `STEP_CYCLES`.
- `D_ACK` / `U_ACK`:
  - Wait until the synchronized ack equals 1 (`D_ACK`) or 0 (`U_ACK`); advance on the next edge.
  - A timeout counter starts at 0 on entry. If the counter reaches `ACK_TIMEOUT-1` without a match, set `err_o` and advance anyway.
- Ack path: `switch_ack_ni` passes through a 2-flop synchronizer, adding 2 cycles of latency.
- `req_ready_o` = 1 only in `ON` or `OFF`.
- Accepted request with target equal to the current state: no sequence runs; `done_o` pulses the next cycle.
- Accepted request with the opposite target: the sequence starts the next cycle.
- `err_o` clears when the next request is accepted.
- `busy_o` = 1 in every state other than `ON` and `OFF`.
- `on_o` = 1 only in `ON`.
- `done_o` is high for the first cycle in `ON` or `OFF` after a sequence, or after a no-op request.
- Requests arriving while busy are not accepted; `req_ready_o` = 0. The requester holds `req_valid_i`.
- Reset (asynchronous, any state including mid-sequence):
  - State becomes `ON`.
  - `switch_no`, `iso_no`, `rst_no`, `clkgate_en_no` = 1.
  - `on_o` = 1, `req_ready_o` = 1.
  - `busy_o`, `done_o`, `err_o` = 0.
  - Counters and synchronizer flops = 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Power-down, request accepted at edge 0, `STEP_CYCLES`=2, ack rising at cycle A:
  - `clkgate_en_no`=0 at cycle 1; `iso_no`=0 at 3; `rst_no`=0 at 5; `switch_no`=0 at 7.
  - `D_ACK` from cycle 9.
  - `OFF` and `done_o` at max(9, A+2)+1.
- Power-up from `OFF`, request at edge 0, ack falling at cycle A:
  - `switch_no`=1 at cycle 1; `U_ACK` from 3.
  - `rst_no`=1 at max(3, A+2)+1 = R; `iso_no`=1 at R+2; `clkgate_en_no`=1 at R+4.
  - `ON` and `done_o` at R+6.
- Timeout: the wait state lasts exactly `ACK_TIMEOUT` cycles. `err_o` rises on the exit edge.
- An ack already matching on entry to a wait state still costs one wait cycle.
- Counter width is $clog2(max(STEP_CYCLES, ACK_TIMEOUT))+1. Counters never wrap.

## Structure
- `power_seq_pkg`: state enum `pwr_seq_state_e` and step-output encoding constants.
- Sub-module `power_seq_ack_sync`: 2-flop synchronizer, async active-high reset to 0.
- The FSM, step counter and timeout counter live in the top module.
- Harness: one instance per domain. The switch model (15-cycle delayed `switch_no` → `switch_ack_ni`) drives the ack.

## Test plan
- Reset mid-`D_RST`: all four control outputs return to 1 immediately, `on_o`=1, `err_o`=0.
- Power-down, STEP=2, 15-cycle switch model (ack rises at 22): output edges at 1/3/5/7, `done_o` at 25, `on_o`=0.
- Power-up from `OFF`, same model (ack falls at 16): `switch_no` at 1, `rst_no` at 19, `iso_no` at 21, `clkgate_en_no` at 23, `done_o` at 25.
- Ack stuck low during power-down, `ACK_TIMEOUT`=64: `D_ACK` lasts cycles 9–72, `OFF` at 73, `err_o`=1 until the next accepted request.
- Request for power-on while already `ON`: `done_o` pulses at cycle 1; no output toggles.
- Request held valid during a sequence: `req_ready_o`=0 throughout; accepted on the `done_o` cycle; the opposite sequence starts the next cycle.

Source files
------------

// File: rtl/power_seq_pkg.sv
// Shared types for the power-domain sequencer: FSM state encoding and the
// per-state levels of the four domain control nets.
package power_seq_pkg;

    typedef enum logic [3:0] {
        ST_ON,
        ST_D_CLK,
        ST_D_ISO,
        ST_D_RST,
        ST_D_SW,
        ST_D_ACK,
        ST_OFF,
        ST_U_SW,
        ST_U_ACK,
        ST_U_RST,
        ST_U_ISO,
        ST_U_CLK
    } pwr_seq_state_e;

    // All four nets are active-low: 1 means released/powered.
    typedef struct packed {
        logic sw;
        logic iso;
        logic rst;
        logic clkgate;
    } pwr_ctrl_t;

    localparam pwr_ctrl_t CTRL_ALL_ON    = 4'b1111;
    localparam pwr_ctrl_t CTRL_CLK_GATED = 4'b1110;
    localparam pwr_ctrl_t CTRL_ISOLATED  = 4'b1100;
    localparam pwr_ctrl_t CTRL_IN_RESET  = 4'b1000;
    localparam pwr_ctrl_t CTRL_ALL_OFF   = 4'b0000;

    function automatic pwr_ctrl_t ctrl_for_state(pwr_seq_state_e s);
        pwr_ctrl_t c;
        c = CTRL_ALL_ON;
        unique case (s)
            ST_ON:                    c = CTRL_ALL_ON;
            ST_D_CLK:                 c = CTRL_CLK_GATED;
            ST_D_ISO:                 c = CTRL_ISOLATED;
            ST_D_RST:                 c = CTRL_IN_RESET;
            ST_D_SW, ST_D_ACK, ST_OFF: c = CTRL_ALL_OFF;
            ST_U_SW, ST_U_ACK:        c = CTRL_IN_RESET;
            ST_U_RST:                 c = CTRL_ISOLATED;
            ST_U_ISO:                 c = CTRL_CLK_GATED;
            ST_U_CLK:                 c = CTRL_ALL_ON;
            default:                  c = CTRL_ALL_ON;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/power_domain_sequencer_if.sv
// Request handshake and status bundle between the power-control registers
// (master) and one domain sequencer (slave).
interface power_domain_sequencer_if;
    logic req_valid;
    logic req_on;
    logic req_ready;
    logic on;
    logic busy;
    logic done;
    logic err;

    modport master (
        output req_valid, req_on,
        input  req_ready, on, busy, done, err
    );

    modport slave (
        input  req_valid, req_on,
        output req_ready, on, busy, done, err
    );
endinterface

// File: rtl/power_seq_ack_sync.sv
// Two-flop synchronizer for the switch-cell acknowledge, which arrives
// asynchronously to the sequencer clock.
module power_seq_ack_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // NOTE: sequential state is written with non-blocking assignments so both
    // stages sample the pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/power_domain_sequencer.sv
// Orders clock gate, isolation, reset and power switch of one gated domain on
// power-down, reverses them on power-up, and bounds the wait for the switch ack.
module power_domain_sequencer
    import power_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    power_domain_sequencer_if.slave   req_if,
    input  logic                      switch_ack_ni,
    output logic                      switch_no,
    output logic                      iso_no,
    output logic                      rst_no,
    output logic                      clkgate_en_no
);
    localparam int unsigned CNT_MAX = (STEP_CYCLES > ACK_TIMEOUT) ? STEP_CYCLES : ACK_TIMEOUT;
    localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    pwr_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    pwr_ctrl_t        ctrl_q, ctrl_d;
    logic             ready_q, ready_d;
    logic             on_q, on_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ack_sync;
    logic             accept;
    logic             step_done;
    logic             in_ack_wait;

    power_seq_ack_sync u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (switch_ack_ni),
        .q_o   (ack_sync)
    );

    assign accept      = req_if.req_valid && ready_q;
    assign step_done   = (step_cnt_q == STEP_LAST);
    assign in_ack_wait = (state_q == ST_D_ACK) || (state_q == ST_U_ACK);

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_ON: if (accept) begin
                err_d = 1'b0;
                if (req_if.req_on) done_d  = 1'b1;
                else               state_d = ST_D_CLK;
            end
            ST_OFF: if (accept) begin
                err_d = 1'b0;
                if (req_if.req_on) state_d = ST_U_SW;
                else               done_d  = 1'b1;
            end
            ST_D_CLK: if (step_done) state_d = ST_D_ISO;
            ST_D_ISO: if (step_done) state_d = ST_D_RST;
            ST_D_RST: if (step_done) state_d = ST_D_SW;
            ST_D_SW:  if (step_done) state_d = ST_D_ACK;
            ST_D_ACK: begin
                if (ack_sync) begin
                    state_d = ST_OFF;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_OFF;
                    err_d   = 1'b1;
                end
            end
            ST_U_SW:  if (step_done) state_d = ST_U_ACK;
            ST_U_ACK: begin
                if (!ack_sync) begin
                    state_d = ST_U_RST;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_U_RST;
                    err_d   = 1'b1;
                end
            end
            ST_U_RST: if (step_done) state_d = ST_U_ISO;
            ST_U_ISO: if (step_done) state_d = ST_U_CLK;
            ST_U_CLK: if (step_done) state_d = ST_ON;
            default:  state_d = ST_ON;
        endcase

        // Completion pulse for the first cycle in a stable state after a sequence.
        if ((state_d != state_q) && (state_d == ST_ON || state_d == ST_OFF)) begin
            done_d = 1'b1;
        end

        // Both counters restart on every state change and saturate instead of wrapping.
        step_cnt_d = step_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (state_d != state_q) begin
            step_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else begin
            if (step_cnt_q != STEP_LAST)              step_cnt_d = step_cnt_q + CNT_W'(1);
            if (in_ack_wait && tmo_cnt_q != TMO_LAST) tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
        end

        // Outputs are registered from the next state so they change with it.
        ctrl_d  = ctrl_for_state(state_d);
        ready_d = (state_d == ST_ON) || (state_d == ST_OFF);
        on_d    = (state_d == ST_ON);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ON;
            step_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            ctrl_q     <= CTRL_ALL_ON;
            ready_q    <= 1'b1;
            on_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ctrl_q     <= ctrl_d;
            ready_q    <= ready_d;
            on_q       <= on_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign switch_no      = ctrl_q.sw;
    assign iso_no         = ctrl_q.iso;
    assign rst_no         = ctrl_q.rst;
    assign clkgate_en_no  = ctrl_q.clkgate;
    assign req_if.req_ready = ready_q;
    assign req_if.on        = on_q;
    assign req_if.busy      = busy_q;
    assign req_if.done      = done_q;
    assign req_if.err       = err_q;
endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench: one sequencer driven by a 15-cycle delayed switch model,
// with hand-computed cycle numbers counted from each request's accept edge.
module tb_power_domain_sequencer;
    logic clk;
    logic rst;
    logic switch_ack_n;
    logic switch_n;
    logic iso_n;
    logic rst_n_dom;
    logic clkgate_n;
    logic ack_stuck_low;
    logic [14:0] sw_hist;
    int   total;
    int   bad;
    int   cyc;

    power_domain_sequencer_if pif ();

    power_domain_sequencer #(
        .STEP_CYCLES (2),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_if        (pif.slave),
        .switch_ack_ni (switch_ack_n),
        .switch_no     (switch_n),
        .iso_no        (iso_n),
        .rst_no        (rst_n_dom),
        .clkgate_en_no (clkgate_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch model: ack_n in cycle c is the inverse of switch_no in cycle c-15.
    always @(posedge clk or posedge rst) begin
        if (rst) sw_hist <= '1;
        else     sw_hist <= {sw_hist[13:0], switch_n};
    end
    assign switch_ack_n = ack_stuck_low ? 1'b0 : ~sw_hist[14];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctrl();
        return {4'b0, switch_n, iso_n, rst_n_dom, clkgate_n};
    endfunction

    // Called at a negedge; the next posedge is accept edge 0 and returns in cycle 1.
    task automatic issue(input logic on, input bit hold);
        pif.req_valid = 1'b1;
        pif.req_on    = on;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        if (!hold) pif.req_valid = 1'b0;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b0;
        ack_stuck_low = 1'b0;
        pif.req_valid = 1'b0;
        pif.req_on    = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_ctrl",  ctrl(), 8'hf);
        check("reset_on",    pif.on, 1);
        check("reset_ready", pif.req_ready, 1);
        check("reset_busy",  pif.busy, 0);
        check("reset_done",  pif.done, 0);
        check("reset_err",   pif.err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // No-op power-on while already ON.
        issue(1'b1, 1'b0);
        check("noop_done_c1", pif.done, 1);
        check("noop_ctrl_c1", ctrl(), 8'hf);
        check("noop_on_c1",   pif.on, 1);
        to_cycle(2);
        check("noop_done_c2", pif.done, 0);
        check("noop_ctrl_c2", ctrl(), 8'hf);
        repeat (20) @(negedge clk);

        // Power-down with the switch model: ack rises at 22, OFF at 25.
        issue(1'b0, 1'b0);
        check("pd_ctrl_c1", ctrl(), 8'he);
        check("pd_busy_c1", pif.busy, 1);
        check("pd_ready_c1", pif.req_ready, 0);
        to_cycle(2);  check("pd_ctrl_c2", ctrl(), 8'he);
        to_cycle(3);  check("pd_ctrl_c3", ctrl(), 8'hc);
        to_cycle(4);  check("pd_ctrl_c4", ctrl(), 8'hc);
        to_cycle(5);  check("pd_ctrl_c5", ctrl(), 8'h8);
        to_cycle(6);  check("pd_ctrl_c6", ctrl(), 8'h8);
        to_cycle(7);  check("pd_ctrl_c7", ctrl(), 8'h0);
        to_cycle(24); check("pd_done_c24", pif.done, 0);
                      check("pd_busy_c24", pif.busy, 1);
        to_cycle(25); check("pd_done_c25", pif.done, 1);
                      check("pd_on_c25", pif.on, 0);
                      check("pd_busy_c25", pif.busy, 0);
                      check("pd_ready_c25", pif.req_ready, 1);
                      check("pd_err_c25", pif.err, 0);
        to_cycle(26); check("pd_done_c26", pif.done, 0);
        to_cycle(40);

        // Power-up with the switch model: ack falls at 16, rst_no at 19.
        issue(1'b1, 1'b0);
        check("pu_ctrl_c1", ctrl(), 8'h8);
        to_cycle(18); check("pu_ctrl_c18", ctrl(), 8'h8);
        to_cycle(19); check("pu_ctrl_c19", ctrl(), 8'hc);
        to_cycle(20); check("pu_ctrl_c20", ctrl(), 8'hc);
        to_cycle(21); check("pu_ctrl_c21", ctrl(), 8'he);
        to_cycle(22); check("pu_ctrl_c22", ctrl(), 8'he);
        to_cycle(23); check("pu_ctrl_c23", ctrl(), 8'hf);
                      check("pu_on_c23", pif.on, 0);
        to_cycle(24); check("pu_done_c24", pif.done, 0);
        to_cycle(25); check("pu_done_c25", pif.done, 1);
                      check("pu_on_c25", pif.on, 1);
                      check("pu_busy_c25", pif.busy, 0);
        to_cycle(30);

        // Ack stuck low during power-down: D_ACK spans 9..72, OFF with err at 73.
        ack_stuck_low = 1'b1;
        issue(1'b0, 1'b0);
        to_cycle(72); check("tmo_busy_c72", pif.busy, 1);
                      check("tmo_err_c72", pif.err, 0);
        to_cycle(73); check("tmo_done_c73", pif.done, 1);
                      check("tmo_err_c73", pif.err, 1);
                      check("tmo_ctrl_c73", ctrl(), 8'h0);
                      check("tmo_on_c73", pif.on, 0);
        to_cycle(80); check("tmo_err_c80", pif.err, 1);
                      check("tmo_done_c80", pif.done, 0);
        ack_stuck_low = 1'b0;
        to_cycle(90);

        // Power-up clears err; an opposite request held from cycle 5 waits for done.
        issue(1'b1, 1'b0);
        check("hold_err_clr_c1", pif.err, 0);
        to_cycle(4);
        pif.req_valid = 1'b1;
        pif.req_on    = 1'b0;
        for (int c = 5; c <= 24; c++) begin
            to_cycle(c);
            check($sformatf("hold_ready_c%0d", c), pif.req_ready, 0);
        end
        to_cycle(25); check("hold_done_c25", pif.done, 1);
                      check("hold_ready_c25", pif.req_ready, 1);
                      check("hold_on_c25", pif.on, 1);
        to_cycle(26); check("hold_ctrl_c26", ctrl(), 8'he);
                      check("hold_busy_c26", pif.busy, 1);
                      check("hold_on_c26", pif.on, 0);
        pif.req_valid = 1'b0;

        // Reset asserted mid-D_RST of that power-down releases everything at once.
        to_cycle(30); check("mid_ctrl_c30", ctrl(), 8'h8);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ctrl",  ctrl(), 8'hf);
        check("mid_rst_on",    pif.on, 1);
        check("mid_rst_err",   pif.err, 0);
        check("mid_rst_busy",  pif.busy, 0);
        check("mid_rst_ready", pif.req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_ctrl", ctrl(), 8'hf);
        check("post_rst_done", pif.done, 0);
        check("post_rst_on",   pif.on, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
